// File: rtl/dnn_argmax_fix_if.sv
// Handshake bundle between the inference engine, the argmax stage and the consumer.
// Optional scoreboard signals exist only when DNN_ARGMAX_SCORE_EN is defined.
interface dnn_argmax_fix_if #(
    parameter int DATA_WIDTH  = 2,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] scores [NUM_CLASSES];
    logic                         ack;
    logic                         busy;
    logic                         valid;
    logic [IDX_WIDTH-1:0]         class_idx;
    logic signed [DATA_WIDTH-1:0] max_val;
    logic                         tie;
`ifdef DNN_ARGMAX_SCORE_EN
    logic [IDX_WIDTH-1:0]         label;
    logic                         clr_cnt;
    logic [15:0]                  total_cnt;
    logic [15:0]                  correct_cnt;

    modport master (
        output start, scores, ack, label, clr_cnt,
        input  busy, valid, class_idx, max_val, tie,
        input  total_cnt, correct_cnt
    );
    modport slave (
        input  start, scores, ack, label, clr_cnt,
        output busy, valid, class_idx, max_val, tie,
        output total_cnt, correct_cnt
    );
`else
    modport master (
        output start, scores, ack,
        input  busy, valid, class_idx, max_val, tie
    );
    modport slave (
        input  start, scores, ack,
        output busy, valid, class_idx, max_val, tie
    );
`endif
endinterface

// File: rtl/dnn_argmax_fix.sv
// Serial argmax over the class scores, one compare per clock, lowest index wins ties.
// Define DNN_ARGMAX_SCORE_EN to add label-based accuracy counters.
module dnn_argmax_fix #(
    parameter int DATA_WIDTH  = 2,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input logic              clk,
    input logic              rst,
    dnn_argmax_fix_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] snap [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] best;
    logic signed [DATA_WIDTH-1:0] best_n;
    logic signed [DATA_WIDTH-1:0] cur;
    logic [IDX_WIDTH-1:0]         cnt;
    logic [IDX_WIDTH-1:0]         best_idx;
    logic [IDX_WIDTH-1:0]         idx_n;
    logic                         tie_q;
    logic                         tie_n;
    logic                         last;
    logic                         load;

    logic                         busy_q;
    logic                         valid_q;
    logic [IDX_WIDTH-1:0]         idx_o;
    logic signed [DATA_WIDTH-1:0] max_o;
    logic                         tie_o;

    // A start during a scan is dropped; from IDLE or DONE it (re)loads.
    assign load = bus.start && (state != SCAN);
    assign last = (cnt == IDX_WIDTH'(NUM_CLASSES - 1));
    assign cur  = snap[cnt];

    always_comb begin
        best_n = best;
        idx_n  = best_idx;
        tie_n  = tie_q;
        if (cur > best) begin
            best_n = cur;
            idx_n  = cnt;
            tie_n  = 1'b0;
        end else if (cur == best) begin
            tie_n  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
            best     <= '0;
            best_idx <= '0;
            tie_q    <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            idx_o    <= '0;
            max_o    <= '0;
            tie_o    <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= bus.scores[i];
            best     <= bus.scores[0];
            best_idx <= '0;
            tie_q    <= 1'b0;
            cnt      <= IDX_WIDTH'(1);
            state    <= SCAN;
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                SCAN: begin
                    best     <= best_n;
                    best_idx <= idx_n;
                    tie_q    <= tie_n;
                    if (last) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        idx_o   <= idx_n;
                        max_o   <= best_n;
                        tie_o   <= tie_n;
                    end else begin
                        cnt <= cnt + IDX_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.class_idx = idx_o;
    assign bus.max_val   = max_o;
    assign bus.tie       = tie_o;

`ifdef DNN_ARGMAX_SCORE_EN
    logic [IDX_WIDTH-1:0] label_q;
    logic [15:0]          total_q;
    logic [15:0]          correct_q;
    logic                 finish;

    assign finish = (state == SCAN) && last && !load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            label_q   <= '0;
            total_q   <= '0;
            correct_q <= '0;
        end else begin
            if (load) label_q <= bus.label;
            if (bus.clr_cnt) begin
                total_q   <= '0;
                correct_q <= '0;
            end else if (finish) begin
                if (total_q != 16'hFFFF) total_q <= total_q + 16'd1;
                if (idx_n == label_q && !tie_n && correct_q != 16'hFFFF)
                    correct_q <= correct_q + 16'd1;
            end
        end
    end

    assign bus.total_cnt   = total_q;
    assign bus.correct_cnt = correct_q;
`endif
endmodule
